// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Holds the PC via Stall_PC until the registered result is presented with a one-cycle Done pulse.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            rst_n,
   input  logic            Start,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] Rs1_Data,
   input  logic [XLEN-1:0] Rs2_Data,
   output logic [XLEN-1:0] Result,
   output logic            Done,
   output logic            Busy,
   output logic            Stall_PC
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t              state_r;
   logic [CW-1:0]       count_r;
   logic [2:0]          op_r;
   logic [XLEN-1:0]     mcand_r;
   logic [2*XLEN-1:0]   acc_r;
   logic [XLEN-1:0]     rem_r;
   logic                neg_q_r;
   logic                neg_r_r;

   logic                signed_a_s;
   logic                signed_b_s;
   logic                a_neg_s;
   logic                b_neg_s;
   logic [XLEN-1:0]     a_mag_s;
   logic [XLEN-1:0]     b_mag_s;
   logic                div_zero_s;
   logic                div_ovf_s;
   logic [XLEN-1:0]     fast_res_s;
   logic [XLEN:0]       mul_sum_s;
   logic [2*XLEN-1:0]   mul_nxt_s;
   logic [XLEN:0]       div_shift_s;
   logic [XLEN:0]       div_trial_s;
   logic                div_ok_s;
   logic [XLEN-1:0]     rem_nxt_s;
   logic [XLEN-1:0]     quo_nxt_s;
   logic [2*XLEN-1:0]   prod_s;
   logic [XLEN-1:0]     calc_res_s;

   function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

   // Operand decode in IDLE: signedness, magnitudes and the two divide fast paths
   always_comb begin
      signed_a_s = !(Funct3[0] && (Funct3[1] || Funct3[2]));
      signed_b_s = signed_a_s && (Funct3 != 3'b010);
      a_neg_s    = signed_a_s && Rs1_Data[XLEN-1];
      b_neg_s    = signed_b_s && Rs2_Data[XLEN-1];
      a_mag_s    = apply_sign(Rs1_Data, a_neg_s);
      b_mag_s    = apply_sign(Rs2_Data, b_neg_s);
      div_zero_s = Funct3[2] && (Rs2_Data == {XLEN{1'b0}});
      div_ovf_s  = Funct3[2] && !Funct3[0]
                   && (Rs1_Data == {1'b1, {(XLEN-1){1'b0}}})
                   && (Rs2_Data == {XLEN{1'b1}});
      if (div_zero_s) begin
         fast_res_s = Funct3[1] ? Rs1_Data : {XLEN{1'b1}};
      end else begin
         fast_res_s = Funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
      end
   end

   // One iteration of each datapath plus the sign-corrected result of the final step
   always_comb begin
      mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
      mul_nxt_s   = {mul_sum_s, acc_r[XLEN-1:1]};
      div_shift_s = {rem_r, acc_r[XLEN-1]};
      div_trial_s = div_shift_s - {1'b0, mcand_r};
      div_ok_s    = !div_trial_s[XLEN];
      rem_nxt_s   = div_ok_s ? div_trial_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
      quo_nxt_s   = {acc_r[XLEN-2:0], div_ok_s};
      prod_s      = neg_q_r ? (~mul_nxt_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : mul_nxt_s;
      case (op_r)
         3'b000:                 calc_res_s = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: calc_res_s = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         calc_res_s = apply_sign(quo_nxt_s, neg_q_r);
         3'b110, 3'b111:         calc_res_s = apply_sign(rem_nxt_s, neg_r_r);
         default:                calc_res_s = {XLEN{1'b0}};
      endcase
   end

   // Control FSM with registered Result/Done/Busy and iteration state
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         count_r <= {CW{1'b0}};
         op_r    <= 3'b000;
         mcand_r <= {XLEN{1'b0}};
         acc_r   <= {(2*XLEN){1'b0}};
         rem_r   <= {XLEN{1'b0}};
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         Result  <= {XLEN{1'b0}};
         Done    <= 1'b0;
         Busy    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               Done <= 1'b0;
               if (Start) begin
                  op_r    <= Funct3;
                  count_r <= CW'(XLEN - 1);
                  neg_q_r <= a_neg_s ^ b_neg_s;
                  neg_r_r <= a_neg_s;
                  rem_r   <= {XLEN{1'b0}};
                  if (Funct3[2]) begin
                     mcand_r <= b_mag_s;
                     acc_r   <= {{XLEN{1'b0}}, a_mag_s};
                  end else begin
                     mcand_r <= a_mag_s;
                     acc_r   <= {{XLEN{1'b0}}, b_mag_s};
                  end
                  if (div_zero_s || div_ovf_s) begin
                     Result  <= fast_res_s;
                     Done    <= 1'b1;
                     state_r <= DONE;
                  end else begin
                     Busy    <= 1'b1;
                     state_r <= CALC;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               if (!Start) begin
                  Busy    <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  acc_r   <= op_r[2] ? {acc_r[2*XLEN-1:XLEN], quo_nxt_s} : mul_nxt_s;
                  rem_r   <= rem_nxt_s;
                  count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                  if (count_r == {CW{1'b0}}) begin
                     Result  <= calc_res_s;
                     Done    <= 1'b1;
                     Busy    <= 1'b0;
                     state_r <= DONE;
                  end else begin
                     state_r <= CALC;
                  end
               end
            end
            DONE: begin
               Done    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               Done    <= 1'b0;
               Busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign Stall_PC = Start && (state_r != DONE);

endmodule
